// File: rtl/dpram_rmw_pkg.sv
// dpram_rmw_pkg: op encodings and FSM states shared by dpram_rmw_ctrl and its ALU
package dpram_rmw_pkg;
    typedef enum logic [1:0] {
        READ     = 2'b00,
        WRITE    = 2'b01,
        SET_BITS = 2'b10,
        CLR_BITS = 2'b11
    } op_t;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;
endpackage

// File: rtl/dpram_rmw_alu.sv
// dpram_rmw_alu: combinational modify step producing the new word from op, old word and mask
module dpram_rmw_alu import dpram_rmw_pkg::*; #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] old_data,
    input  logic [DATA_WIDTH-1:0] mask,
    output logic [DATA_WIDTH-1:0] new_data
);
    always_comb
        new_data = op == WRITE    ? mask :
                   op == SET_BITS ? old_data | mask :
                   op == CLR_BITS ? old_data & ~mask : old_data;
endmodule

// File: rtl/dpram_rmw_ctrl.sv
// dpram_rmw_ctrl: single-op-in-flight read-modify-write controller for one registered RAM port.
// Define DPRAM_RMW_STATS_EN to add a saturating 16-bit op_count of completed responses.
module dpram_rmw_ctrl import dpram_rmw_pkg::*; #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_old,
    output logic [DATA_WIDTH-1:0] rsp_new,
`ifdef DPRAM_RMW_STATS_EN
    output logic [15:0]           op_count,
`endif
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_q
);
    state_t state, state_n;
    op_t op_r;
    logic [DATA_WIDTH-1:0] mask_r, old_r, alu_new;

    dpram_rmw_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op(op_r), .old_data(mem_q), .mask(mask_r), .new_data(alu_new)
    );

    assign cmd_ready = state == IDLE;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = cmd_valid ? RD : IDLE;
            RD:      state_n = CAP;
            CAP:     state_n = WR;
            WR:      state_n = RESP;
            RESP:    state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_valid) begin
            op_r   <= op_t'(cmd_op);
            mask_r <= cmd_data;
        end
        if (state == CAP)
            old_r <= mem_q;
    end

    // mem_wdata carries the modified word into WR, where it also becomes rsp_new
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_old   <= '0;
            rsp_new   <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                mem_addr <= cmd_addr;
                mem_wen  <= 1'b0;
            end
            if (state == CAP) begin
                mem_wen   <= op_r != READ;
                mem_wdata <= alu_new;
            end
            if (state == WR) begin
                mem_wen   <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_old   <= old_r;
                rsp_new   <= mem_wdata;
            end
            if (state == RESP && rsp_ready)
                rsp_valid <= 1'b0;
        end
    end

`ifdef DPRAM_RMW_STATS_EN
    always_ff @(posedge clk)
        if (rst)
            op_count <= '0;
        else if (state == RESP && rsp_ready && op_count != 16'hFFFF)
            op_count <= op_count + 16'd1;
`endif
endmodule

// File: tb/tb_dpram_rmw_ctrl.sv
// tb_dpram_rmw_ctrl: randomized and directed checks of dpram_rmw_ctrl against a word-array model,
// with a 64x64 dual-port RAM whose port A serves the controller and port B serves the bench.
module tb_dpram_rmw_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, mem_wen;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_addr, mem_addr;
    logic [63:0] cmd_data, rsp_old, rsp_new, mem_wdata, mem_q;
`ifdef DPRAM_RMW_STATS_EN
    logic [15:0] op_count;
`endif
    logic        b_we;
    logic [5:0]  b_addr;
    logic [63:0] b_wdata;
    logic [63:0] ram [64];
    logic [63:0] model [64];
    logic [63:0] ro, rn;
    int          checks = 0, failures = 0, ops = 0;

    always #5 clk = ~clk;

    dpram_rmw_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_old(rsp_old), .rsp_new(rsp_new),
`ifdef DPRAM_RMW_STATS_EN
        .op_count(op_count),
`endif
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_q(mem_q)
    );

    // registered-read, read-before-write RAM; port A = controller, port B = bench
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        if (b_we) ram[b_addr] <= b_wdata;
        mem_q <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [63:0] d);
        b_we = 1'b1; b_addr = a; b_wdata = d;
        model[a] = d;
        @(negedge clk);
        b_we = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [5:0] a, input logic [63:0] d,
                         input int hold, output logic [63:0] got_old, output logic [63:0] got_new);
        logic [63:0] o, n;
        o = model[a];
        case (op)
            2'b00: n = o;
            2'b01: n = d;
            2'b10: n = o | d;
            default: n = o & ~d;
        endcase
        @(negedge clk);
        chk("idle_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 6'($urandom); cmd_data = {$urandom, $urandom};
        rsp_ready = 1'($urandom);
        chk("k_wen", 64'(mem_wen), 64'(0));
        chk("k_addr", 64'(mem_addr), 64'(a));
        chk("k_busy", 64'(cmd_ready), 64'(0));
        @(negedge clk);
        rsp_ready = 1'($urandom);
        chk("k1_wen", 64'(mem_wen), 64'(0));
        chk("k1_addr", 64'(mem_addr), 64'(a));
        @(negedge clk);
        rsp_ready = 1'($urandom);
        chk("k2_wen", 64'(mem_wen), 64'(op != 2'b00));
        chk("k2_addr", 64'(mem_addr), 64'(a));
        chk("k2_rsp_valid", 64'(rsp_valid), 64'(0));
        if (op != 2'b00) chk("k2_wdata", mem_wdata, n);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("k3_wen", 64'(mem_wen), 64'(0));
        chk("k3_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("k3_rsp_old", rsp_old, o);
        chk("k3_rsp_new", rsp_new, n);
        got_old = rsp_old; got_new = rsp_new;
        model[a] = n;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_addr = 6'($urandom); cmd_data = {$urandom, $urandom};
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'(1));
            chk("hold_old", rsp_old, o);
            chk("hold_new", rsp_new, n);
            chk("hold_busy", 64'(cmd_ready), 64'(0));
            chk("hold_wen", 64'(mem_wen), 64'(0));
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ops++;
        chk("hs_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("hs_ready", 64'(cmd_ready), 64'(1));
        chk("ram_word", ram[a], model[a]);
    endtask

    task automatic rst_mid(input logic [5:0] a, input logic [63:0] d, input bit in_wr);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = a; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        if (in_wr) @(negedge clk);
        chk("pre_rst_wen", 64'(mem_wen), 64'(in_wr));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (in_wr) model[a] = d;
        ops = 0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("abort_wen", 64'(mem_wen), 64'(0));
            @(negedge clk);
        end
        chk("abort_ready", 64'(cmd_ready), 64'(1));
        chk("abort_addr", 64'(mem_addr), 64'(0));
        chk("abort_ram", ram[a], model[a]);
`ifdef DPRAM_RMW_STATS_EN
        chk("abort_op_count", 64'(op_count), 64'(0));
`endif
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) preload(6'(i), {$urandom, $urandom});
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_wen", 64'(mem_wen), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_wdata", mem_wdata, 64'(0));
        chk("rst_rsp_old", rsp_old, 64'(0));
        chk("rst_rsp_new", rsp_new, 64'(0));
`ifdef DPRAM_RMW_STATS_EN
        chk("rst_op_count", 64'(op_count), 64'(0));
`endif
        do_op(2'b01, 6'd5, 64'hDEAD_BEEF, 0, ro, rn);
        chk("write5_new", rn, 64'hDEAD_BEEF);
        chk("write5_ram", ram[5], 64'hDEAD_BEEF);
        preload(6'd7, 64'h00F0);
        do_op(2'b10, 6'd7, 64'h000F, 0, ro, rn);
        chk("set_old", ro, 64'h00F0);
        chk("set_new", rn, 64'h00FF);
        do_op(2'b11, 6'd7, 64'h00F0, 0, ro, rn);
        chk("clr_old", ro, 64'h00FF);
        chk("clr_new", rn, 64'h000F);
        preload(6'd63, '1);
        do_op(2'b00, 6'd63, {$urandom, $urandom}, 0, ro, rn);
        chk("read63_old", ro, '1);
        chk("read63_new", rn, '1);
        do_op(2'b01, 6'd20, {$urandom, $urandom}, 10, ro, rn);
        for (int i = 0; i < 40; i++)
            do_op(2'($urandom), 6'($urandom), {$urandom, $urandom}, int'($urandom_range(3)), ro, rn);
`ifdef DPRAM_RMW_STATS_EN
        chk("op_count", 64'(op_count), 64'(ops));
`endif
        preload(6'd9, 64'h1);
        rst_mid(6'd9, {$urandom, $urandom}, 1'b0);
        chk("rst_cap_ram9", ram[9], 64'h1);
        rst_mid(6'd12, {$urandom, $urandom}, 1'b1);
        for (int i = 0; i < 10; i++)
            do_op(2'($urandom), 6'($urandom), {$urandom, $urandom}, int'($urandom_range(2)), ro, rn);
        do_op(2'b00, 6'd9, '0, 0, ro, rn);
        chk("ram9_after", ro, 64'h1);
`ifdef DPRAM_RMW_STATS_EN
        chk("op_count_end", 64'(op_count), 64'(ops));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
